// File: rtl/score_keeper.sv
// Frame-synchronous point/score controller for ping-pong: detects wall misses on fsync,
// counts points, times the post-point holdoff, requests serves. Optional SCORE_AUTORESTART_EN.
module score_keeper #(
  parameter int HRES           = 1280,
  parameter int BALL_SIZE      = 50,
  parameter int WIN_SCORE      = 9,
  parameter int HOLD_FRAMES    = 60,
  parameter int RESTART_FRAMES = 180
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               fsync,
  input  logic signed [11:0] ball_hpos,
  input  logic               restart,
  output logic [3:0]         score_l,
  output logic [3:0]         score_r,
  output logic               point_l,
  output logic               point_r,
  output logic               serve_req,
  output logic               game_over,
  output logic               winner
);

  localparam int CNT_W = 16;

  // The scoreboard renders a single digit, so the winning score must be one.
  if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win_score
    $error("score_keeper: WIN_SCORE must be in 1..9");
  end
  if (HOLD_FRAMES < 0 || HOLD_FRAMES > 65535) begin : g_bad_hold
    $error("score_keeper: HOLD_FRAMES must be in 0..65535");
  end
  if (RESTART_FRAMES < 0 || RESTART_FRAMES > 65535) begin : g_bad_restart
    $error("score_keeper: RESTART_FRAMES must be in 0..65535");
  end

  localparam int                HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
  localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(HOLD_EFF);
`ifdef SCORE_AUTORESTART_EN
  localparam int                RST_EFF  = (RESTART_FRAMES < 1) ? 1 : RESTART_FRAMES;
  localparam logic [CNT_W-1:0]  RST_LIM  = CNT_W'(RST_EFF);
`endif
  localparam logic [3:0]        WIN_Q    = 4'(WIN_SCORE);
  localparam logic signed [12:0] BALL_W  = 13'(BALL_SIZE);
  localparam logic signed [12:0] HRES_W  = 13'(HRES);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HOLD  = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic             point_l_q, point_l_d;
  logic             point_r_q, point_r_d;
  logic             serve_req_q, serve_req_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;

  logic signed [12:0] right_edge;
  logic               miss_l;
  logic               miss_r;
  logic [CNT_W-1:0]   cnt_inc;
  logic               clear_game;

  // Saturating point increment; a score never passes the winning value.
  function automatic logic [3:0] bump_score(input logic [3:0] s);
    bump_score = (s < WIN_Q) ? s + 4'd1 : WIN_Q;
  endfunction

  // Sign-extend before adding so the right-edge sum cannot overflow.
  always_comb begin
    right_edge = {ball_hpos[11], ball_hpos} + BALL_W;
    miss_l     = (ball_hpos <= 12'sd0);
    miss_r     = (right_edge >= HRES_W);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;
    serve_req_d = 1'b0;
    clear_game  = 1'b0;
    cnt_inc     = cnt_q + 1'b1;

    if (restart) begin
      clear_game = 1'b1;
    end else if (fsync) begin
      case (state_q)
        ARMED: begin
          // Left-wall miss wins a tie: it is checked first.
          if (miss_l) begin
            score_r_d = bump_score(score_r_q);
            point_r_d = 1'b1;
            cnt_d     = '0;
            if (score_r_d == WIN_Q) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else if (miss_r) begin
            score_l_d = bump_score(score_l_q);
            point_l_d = 1'b1;
            cnt_d     = '0;
            if (score_l_d == WIN_Q) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = 1'b0;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          cnt_d = cnt_inc;
          if (cnt_inc >= HOLD_LIM) begin
            serve_req_d = 1'b1;
            state_d     = ARMED;
          end
        end
        OVER: begin
`ifdef SCORE_AUTORESTART_EN
          cnt_d = cnt_inc;
          if (cnt_inc >= RST_LIM) begin
            clear_game = 1'b1;
          end
`endif
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    // A new game starts frozen in HOLD so the ball is served after the holdoff.
    if (clear_game) begin
      state_d     = HOLD;
      cnt_d       = '0;
      score_l_d   = 4'd0;
      score_r_d   = 4'd0;
      winner_d    = 1'b0;
      game_over_d = 1'b0;
      point_l_d   = 1'b0;
      point_r_d   = 1'b0;
      serve_req_d = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      serve_req_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      serve_req_q <= serve_req_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign serve_req = serve_req_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a frame-level game model queues expected outputs per
// driven cycle; they are popped and compared one clock later.
module tb_score_keeper;
  localparam int HOLD = 2;
  localparam int RF   = 3;
  localparam int WIN  = 9;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fsync;
  logic               restart;
  logic signed [11:0] ball_hpos;
  logic [3:0]         score_l, score_r;
  logic               point_l, point_r, serve_req, game_over, winner;

  score_keeper #(
    .HRES(1280), .BALL_SIZE(50), .WIN_SCORE(WIN),
    .HOLD_FRAMES(HOLD), .RESTART_FRAMES(RF)
  ) dut (
    .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync), .ball_hpos(ball_hpos),
    .restart(restart), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .serve_req(serve_req),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sl;
    logic [3:0] sr;
    logic       pl;
    logic       pr;
    logic       sv;
    logic       go;
    logic       wn;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Game model: mode 0 = playing, 1 = frozen after a point, 2 = game finished.
  int m_mode, m_frames, m_sl, m_sr;
  bit m_wn;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 1; m_frames = 0; m_sl = 0; m_sr = 0; m_wn = 0;
  endtask

  task automatic new_game();
    m_sl = 0; m_sr = 0; m_wn = 0; m_mode = 1; m_frames = 0;
  endtask

  task automatic model_step(input bit fs, input int pos, input bit rs, output exp_t e);
    e = '0;
    if (rs) new_game();
    else if (fs) begin
      if (m_mode == 0) begin
        if (pos <= 0) begin
          m_sr++; e.pr = 1'b1; m_frames = 0;
          if (m_sr == WIN) begin m_mode = 2; m_wn = 1; end else m_mode = 1;
        end else if (pos + 50 >= 1280) begin
          m_sl++; e.pl = 1'b1; m_frames = 0;
          if (m_sl == WIN) begin m_mode = 2; m_wn = 0; end else m_mode = 1;
        end
      end else if (m_mode == 1) begin
        m_frames++;
        if (m_frames >= HOLD) begin e.sv = 1'b1; m_mode = 0; end
      end else begin
`ifdef SCORE_AUTORESTART_EN
        m_frames++;
        if (m_frames >= RF) new_game();
`endif
      end
    end
    e.sl = 4'(m_sl);
    e.sr = 4'(m_sr);
    e.go = (m_mode == 2);
    e.wn = m_wn;
  endtask

  task automatic cycle(input bit fs, input int pos, input bit rs);
    exp_t e;
    exp_t want;
    @(negedge clk);
    fsync     = fs;
    ball_hpos = 12'(pos);
    restart   = rs;
    model_step(fs, pos, rs, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      want = sb_q.pop_front();
      check("score_l",   16'(score_l),   16'(want.sl));
      check("score_r",   16'(score_r),   16'(want.sr));
      check("point_l",   16'(point_l),   16'(want.pl));
      check("point_r",   16'(point_r),   16'(want.pr));
      check("serve_req", 16'(serve_req), 16'(want.sv));
      check("game_over", 16'(game_over), 16'(want.go));
      check("winner",    16'(winner),    16'(want.wn));
    end
  endtask

  task automatic frame(input int pos);
    cycle(1'b1, pos, 1'b0);
    repeat (3) cycle(1'b0, pos, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_score_l"},   16'(score_l),   16'd0);
    check({tag, "_score_r"},   16'(score_r),   16'd0);
    check({tag, "_point_l"},   16'(point_l),   16'd0);
    check({tag, "_point_r"},   16'(point_r),   16'd0);
    check({tag, "_serve_req"}, 16'(serve_req), 16'd0);
    check({tag, "_game_over"}, 16'(game_over), 16'd0);
    check({tag, "_winner"},    16'(winner),    16'd0);
  endtask

  initial begin
    rst_n = 1'b0; fsync = 1'b0; restart = 1'b0; ball_hpos = 12'sd600;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: holdoff after reset ends with a serve one cycle after the 2nd fsync.
    frame(600);
    frame(600);

    // T2: left-wall miss scores for the right; misses ignored while frozen.
    frame(-3);
    check("t2_score_r", 16'(score_r), 16'd1);
    frame(-3);
    frame(-3);
    check("t2_score_r_held", 16'(score_r), 16'd1);

    // T3: right-wall boundary at exactly HRES, and one pixel short of it.
    frame(1230);
    check("t3_score_l", 16'(score_l), 16'd1);
    frame(600);
    frame(600);
    frame(1229);
    check("t3_score_l_no_miss", 16'(score_l), 16'd1);

    // T4: run left to 8, then the winning point.
    for (int i = 0; i < 7; i++) begin
      frame(1230);
      frame(600);
      frame(600);
    end
    check("t4_score_l_8", 16'(score_l), 16'd8);
    frame(1230);
    check("t4_score_l_win", 16'(score_l), 16'd9);
    check("t4_game_over", 16'(game_over), 16'd1);
    check("t4_winner", 16'(winner), 16'd0);
    frame(-3);
    frame(-3);
    check("t4_frozen_r", 16'(score_r), 16'd1);

    // T5: restart coinciding with fsync and a left-wall miss.
    cycle(1'b1, -3, 1'b1);
    check("t5_score_l", 16'(score_l), 16'd0);
    check("t5_point_r", 16'(point_r), 16'd0);
    check("t5_game_over", 16'(game_over), 16'd0);
    repeat (3) cycle(1'b0, 600, 1'b0);
    frame(600);
    frame(600);

    // Right player wins.
    for (int i = 0; i < 9; i++) begin
      frame(-3);
      frame(600);
      frame(600);
    end
    check("rwin_winner", 16'(winner), 16'd1);
    frame(600);
`ifdef SCORE_AUTORESTART_EN
    check("auto_cleared_r", 16'(score_r), 16'd0);
    check("auto_game_over", 16'(game_over), 16'd0);
`else
    check("over_held_r", 16'(score_r), 16'd9);
    check("over_held_go", 16'(game_over), 16'd1);
`endif

    // T6: asynchronous reset in the middle of HOLD.
    cycle(1'b0, 600, 1'b1);
    frame(600);
    frame(600);
    frame(-3);
    check("t6_pre_score_r", 16'(score_r), 16'd1);
    @(negedge clk);
    fsync = 1'b0; restart = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random play with occasional restarts.
    for (int i = 0; i < 1500; i++) begin
      int pos;
      bit fs, rs;
      case ($urandom_range(3))
        0:       pos = int'($urandom_range(120)) - 100;
        1:       pos = 1180 + int'($urandom_range(120));
        default: pos = 100 + int'($urandom_range(1000));
      endcase
      fs = ($urandom_range(2) == 0);
      rs = ($urandom_range(199) == 0);
      cycle(fs, pos, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
